// File: rtl/np_rhv_iter.sv
// Iterative hyperbolic CORDIC, vectoring mode, with negative-index range extension.
// Optional input-domain flag on err_out when NP_RHV_RANGE_CHK_EN is defined.
module np_rhv_iter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FRAC_BITS  = 16,
    parameter int unsigned NEG_ITERS  = 2,
    parameter int unsigned POS_ITERS  = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] x_in,
    input  logic signed [DATA_WIDTH-1:0] y_in,
    input  logic signed [DATA_WIDTH-1:0] z_in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] x_out,
    output logic signed [DATA_WIDTH-1:0] y_out,
    output logic signed [DATA_WIDTH-1:0] z_out,
    output logic                         busy
`ifdef NP_RHV_RANGE_CHK_EN
    ,
    output logic                         err_out
`endif
);

    localparam int unsigned CNT_MAX = (POS_ITERS > 13) ? POS_ITERS : 13;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);
    localparam int unsigned TBL_N   = 2 ** CW;

    typedef enum logic [1:0] {ST_IDLE, ST_NEG, ST_POS, ST_DONE} state_e;

    function automatic logic [DATA_WIDTH-1:0] to_fix(input real v);
        return DATA_WIDTH'($rtoi(v * (2.0 ** FRAC_BITS) + 0.5));
    endfunction

    // atanh(1 - 2^-s) = ln(2^(s+1) - 1) / 2
    function automatic real neg_atanh(input int s);
        case (s)
            2:       return 0.9729550745276566;
            3:       return 1.3540251005511053;
            4:       return 1.7169936022425731;
            5:       return 2.0715673631927311;
            default: return 0.0;
        endcase
    endfunction

    function automatic real pos_atanh(input int i);
        real t;
        t = 1.0 / (2.0 ** i);
        case (i)
            0:       return 0.0;
            1:       return 0.5493061443340549;
            2:       return 0.2554128118829953;
            default: return t + t * t * t / 3.0 + t * t * t * t * t / 5.0
                            + t * t * t * t * t * t * t / 7.0;
        endcase
    endfunction

    logic [DATA_WIDTH-1:0] neg_tbl [TBL_N];
    logic [DATA_WIDTH-1:0] pos_tbl [TBL_N];

    for (genvar g = 0; g < TBL_N; g++) begin : g_tbl
        localparam logic [DATA_WIDTH-1:0] NEG_A = to_fix(neg_atanh(g));
        localparam logic [DATA_WIDTH-1:0] POS_B = to_fix(pos_atanh(g));
        assign neg_tbl[g] = NEG_A;
        assign pos_tbl[g] = POS_B;
    end

    state_e                  state_q, state_d;
    logic signed [DATA_WIDTH-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
    logic signed [DATA_WIDTH-1:0] xo_q, xo_d, yo_q, yo_d, zo_q, zo_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    rep_q, rep_d;
    logic                    in_ready_q, in_ready_d;
    logic                    out_valid_q, out_valid_d;
    logic                    busy_q, busy_d;

    logic signed [DATA_WIDTH-1:0] sx, sy, tx, ty, ang;
    logic signed [DATA_WIDTH-1:0] x_step, y_step, z_step;

`ifdef NP_RHV_RANGE_CHK_EN
    logic                    err_q, err_d;
    logic signed [DATA_WIDTH:0] x_ext, y_ext, y_abs;
    logic                    range_bad;

    // |y| is formed one bit wider so the most negative y cannot overflow
    always_comb begin
        x_ext     = {x_in[DATA_WIDTH-1], x_in};
        y_ext     = {y_in[DATA_WIDTH-1], y_in};
        y_abs     = y_ext[DATA_WIDTH] ? -y_ext : y_ext;
        range_bad = x_in[DATA_WIDTH-1] || (x_in == '0) || (y_abs >= x_ext);
    end
`endif

    // Shared add/sub step; negative-index stages use the (1 - 2^-s) factor
    always_comb begin
        sx = x_q >>> cnt_q;
        sy = y_q >>> cnt_q;
        if (state_q == ST_NEG) begin
            tx  = x_q - sx;
            ty  = y_q - sy;
            ang = neg_tbl[cnt_q];
        end else begin
            tx  = sx;
            ty  = sy;
            ang = pos_tbl[cnt_q];
        end
        if (y_q[DATA_WIDTH-1]) begin
            x_step = x_q + ty;
            y_step = y_q + tx;
            z_step = z_q - ang;
        end else begin
            x_step = x_q - ty;
            y_step = y_q - tx;
            z_step = z_q + ang;
        end
    end

    // Next-state and output-register logic
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        xo_d    = xo_q;
        yo_d    = yo_q;
        zo_d    = zo_q;
        cnt_d   = cnt_q;
        rep_d   = rep_q;
`ifdef NP_RHV_RANGE_CHK_EN
        err_d   = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    x_d     = x_in;
                    y_d     = y_in;
                    z_d     = z_in;
                    cnt_d   = CW'(NEG_ITERS + 1);
                    rep_d   = 1'b0;
                    state_d = ST_NEG;
`ifdef NP_RHV_RANGE_CHK_EN
                    err_d   = range_bad;
`endif
                end
            end
            ST_NEG: begin
                x_d = x_step;
                y_d = y_step;
                z_d = z_step;
                if (cnt_q == CW'(2)) begin
                    cnt_d   = CW'(1);
                    state_d = ST_POS;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_POS: begin
                x_d = x_step;
                y_d = y_step;
                z_d = z_step;
                if ((cnt_q == CW'(4) || cnt_q == CW'(13)) && !rep_q) begin
                    rep_d = 1'b1;
                end else begin
                    rep_d = 1'b0;
                    if (cnt_q == CW'(POS_ITERS)) begin
                        xo_d    = x_step;
                        yo_d    = y_step;
                        zo_d    = z_step;
                        cnt_d   = '0;
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
        busy_d      = (state_d == ST_NEG) || (state_d == ST_POS);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            xo_q        <= '0;
            yo_q        <= '0;
            zo_q        <= '0;
            cnt_q       <= '0;
            rep_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef NP_RHV_RANGE_CHK_EN
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            z_q         <= z_d;
            xo_q        <= xo_d;
            yo_q        <= yo_d;
            zo_q        <= zo_d;
            cnt_q       <= cnt_d;
            rep_q       <= rep_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
`ifdef NP_RHV_RANGE_CHK_EN
            err_q       <= err_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign x_out     = xo_q;
    assign y_out     = yo_q;
    assign z_out     = zo_q;
`ifdef NP_RHV_RANGE_CHK_EN
    assign err_out   = err_q;
`endif

endmodule

// File: tb/tb_np_rhv_iter.sv
// Directed bench for np_rhv_iter; expected values are hand-stepped through the
// integer CORDIC recurrence (floor shifts bias results slightly below ideal).
module tb_np_rhv_iter;

    localparam int unsigned DW = 32;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] x_in, y_in, z_in;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] x_out, y_out, z_out;
    logic                 busy;
`ifdef NP_RHV_RANGE_CHK_EN
    logic                 err_out;
`endif

    int checks = 0;
    int errors = 0;
    int n;

    always #5 clk = ~clk;

    np_rhv_iter dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .y_in      (y_in),
        .z_in      (z_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x_out     (x_out),
        .y_out     (y_out),
        .z_out     (z_out),
        .busy      (busy)
`ifdef NP_RHV_RANGE_CHK_EN
        ,
        .err_out   (err_out)
`endif
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    // Called at a negedge with the engine idle; returns at the negedge after the accept edge
    task automatic send(input logic [DW-1:0] x, input logic [DW-1:0] y, input logic [DW-1:0] z);
        chk("in_ready_before_send", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        x_in     = x;
        y_in     = y;
        z_in     = z;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_result(output int cycles);
        cycles = 0;
        while (out_valid !== 1'b1 && cycles < 40) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        x_in      = '0;
        y_in      = '0;
        z_in      = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_x_out", x_out, 32'd0);
        chk("rst_y_out", y_out, 32'd0);
        chk("rst_z_out", z_out, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // y/x = 0.5
        send(32'sd131072, 32'sd65536, 32'sd0);
        chk("c1_busy", 32'(busy), 32'd1);
        chk("c1_in_ready_busy", 32'(in_ready), 32'd0);
        wait_result(n);
        chk("c1_latency", n, 32'd20);
        chk("c1_x_out", x_out, 32'sd30092);
        chk("c1_y_out", y_out, -32'sd4);
        chk("c1_z_out", z_out, 32'sd35992);
        chk("c1_busy_done", 32'(busy), 32'd0);
        chk("c1_in_ready_done", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("c1_out_valid_after_hs", 32'(out_valid), 32'd0);
        chk("c1_in_ready_after_hs", 32'(in_ready), 32'd1);

        // y/x = 0.9, needs the negative-index stages to converge
        send(32'sd65536, 32'sd58982, 32'sd65536);
        wait_result(n);
        chk("c2_latency", n, 32'd20);
        chk("c2_x_out", x_out, 32'sd7565);
        chk("c2_y_out", y_out, -32'sd1);
        chk("c2_z_out", z_out, 32'sd161994);
        @(negedge clk);

        // y/x = -0.5 with downstream stalled for 5 cycles and a second input pending
        out_ready = 1'b0;
        send(32'sd131072, -32'sd65536, 32'sd0);
        wait_result(n);
        chk("c3_latency", n, 32'd20);
        in_valid = 1'b1;
        x_in     = 32'sd131072;
        y_in     = 32'sd65536;
        z_in     = 32'sd0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("c3_hold_out_valid", 32'(out_valid), 32'd1);
            chk("c3_hold_in_ready",  32'(in_ready),  32'd0);
            chk("c3_hold_x_out", x_out, 32'sd30092);
            chk("c3_hold_y_out", y_out, -32'sd4);
            chk("c3_hold_z_out", z_out, -32'sd36004);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("c3_out_valid_after_hs", 32'(out_valid), 32'd0);
        chk("c3_busy_after_hs", 32'(busy), 32'd0);
        chk("c3_in_ready_after_hs", 32'(in_ready), 32'd1);
        @(negedge clk);
        chk("c4_busy_accepted", 32'(busy), 32'd1);
        in_valid = 1'b0;
        wait_result(n);
        chk("c4_latency", n, 32'd20);
        chk("c4_z_out", z_out, 32'sd35992);
        @(negedge clk);

        // Reset after 10 steps aborts the operation
        send(32'sd65536, 32'sd58982, 32'sd65536);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_in_ready",  32'(in_ready),  32'd1);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_busy",      32'(busy),      32'd0);
        chk("mid_rst_x_out", x_out, 32'd0);
        chk("mid_rst_y_out", y_out, 32'd0);
        chk("mid_rst_z_out", z_out, 32'd0);
        rst = 1'b0;
        send(32'sd65536, 32'sd58982, 32'sd65536);
        wait_result(n);
        chk("c5_latency", n, 32'd20);
        chk("c5_x_out", x_out, 32'sd7565);
        chk("c5_z_out", z_out, 32'sd161994);
        @(negedge clk);

`ifdef NP_RHV_RANGE_CHK_EN
        send(32'sd65536, 32'sd65536, 32'sd0);
        wait_result(n);
        chk("err_latency", n, 32'd20);
        chk("err_set", 32'(err_out), 32'd1);
        @(negedge clk);
        send(32'sd131072, 32'sd65536, 32'sd0);
        chk("err_cleared_at_accept", 32'(err_out), 32'd0);
        wait_result(n);
        chk("err_clear", 32'(err_out), 32'd0);
        chk("err_z_out", z_out, 32'sd35992);
        @(negedge clk);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
